// File: rtl/alu_tester_pkg.sv
// Shared constants and types for the ALU tile tester and its golden model.
package alu_tester_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_ERR_CNT = 2'b00;
  localparam logic [1:0] SEL_FF_VEC  = 2'b01;
  localparam logic [1:0] SEL_FF_RES  = 2'b10;
  localparam logic [1:0] SEL_FLAGS   = 2'b11;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference for the 3-bit four-function ALU: vector {op,B,A} -> 8-bit result.
module alu_golden
  import alu_tester_pkg::*;
(
  input  logic [7:0] vec_i,
  output logic [7:0] exp_o
);

  logic [7:0] a, b;
  assign a = {5'b0, vec_i[2:0]};
  assign b = {5'b0, vec_i[5:3]};

  always_comb begin
    exp_o = 8'h00;
    case (vec_i[7:6])
      OP_ADD:  exp_o = a + b;
      OP_SUB:  exp_o = a - b;
      OP_MUL:  exp_o = a * b;
      OP_DIV:  exp_o = (b == 8'h00) ? DIV0_RESULT : a / b;
      default: exp_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/tt_um_alu_tester.sv
// Sweeps all 256 ALU vectors, checks results returned on uio_in, reports status when idle.
// Optional: define ALU_TESTER_STOP_ON_FAIL_EN to halt on the first mismatch.
module tt_um_alu_tester
  import alu_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef ALU_TESTER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [7:0] vec_q, cnt_q, err_cnt_q, ff_vec_q, ff_res_q;
  logic       done_q, fail_q;
  logic [1:0] sync_q;
  logic       start_prev_q;

  logic       start, mismatch, finish;
  logic [7:0] exp_res;

  alu_golden u_golden (
    .vec_i (vec_q),
    .exp_o (exp_res)
  );

  assign start    = sync_q[1] & ~start_prev_q;
  assign mismatch = (uio_in != exp_res);
  assign finish   = (vec_q == 8'hFF) | (STOP_ON_FAIL & mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= 8'h00;
      cnt_q        <= 8'h00;
      err_cnt_q    <= 8'h00;
      ff_vec_q     <= 8'h00;
      ff_res_q     <= 8'h00;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      sync_q       <= 2'b00;
      start_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], ui_in[7]};
      start_prev_q <= sync_q[1];
      if (!ena) begin
        // Abort keeps the error record; done is never set for a cut-short sweep.
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              err_cnt_q <= 8'h00;
              ff_vec_q  <= 8'h00;
              ff_res_q  <= 8'h00;
              done_q    <= 1'b0;
              fail_q    <= 1'b0;
              vec_q     <= 8'h00;
              cnt_q     <= SETTLE_LOAD;
              state_q   <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            if (cnt_q == 8'h00) state_q <= ST_SAMPLE;
            else                cnt_q   <= cnt_q - 8'd1;
          end
          ST_SAMPLE: begin
            if (mismatch) begin
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              if (!fail_q) begin
                ff_vec_q <= vec_q;
                ff_res_q <= uio_in;
                fail_q   <= 1'b1;
              end
            end
            if (finish) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              vec_q   <= vec_q + 8'd1;
              cnt_q   <= SETTLE_LOAD;
              state_q <= ST_DRIVE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    uo_out = 8'h00;
    if (state_q == ST_DRIVE || state_q == ST_SAMPLE) begin
      uo_out = vec_q;
    end else begin
      case (ui_in[1:0])
        SEL_ERR_CNT: uo_out = err_cnt_q;
        SEL_FF_VEC:  uo_out = ff_vec_q;
        SEL_FF_RES:  uo_out = ff_res_q;
        SEL_FLAGS:   uo_out = {done_q, done_q & ~fail_q, fail_q, 5'b0};
        default:     uo_out = 8'h00;
      endcase
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ui;
  assign unused_ui = &{1'b0, ui_in[6:2]};

endmodule

// File: tb/tb_tt_um_alu_tester.sv
// Loopback bench: a behavioural ALU answers the tester, with optional corruption/stuck faults.
module tb_tt_um_alu_tester;

  localparam int S = 4;
`ifdef ALU_TESTER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;

  logic       stuck = 1'b0;
  logic       bad_en = 1'b0;
  logic [7:0] bad_vec = 8'h00;
  logic [7:0] bad_val = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_alu_tester #(.SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  function automatic logic [7:0] ref_alu(input logic [7:0] v);
    int a, b, r;
    a = int'(v[2:0]);
    b = int'(v[5:3]);
    case (v[7:6])
      2'd0:    r = a + b;
      2'd1:    r = (a - b + 256) % 256;
      2'd2:    r = a * b;
      default: r = (b == 0) ? 255 : a / b;
    endcase
    return r[7:0];
  endfunction

  assign uio_in = stuck ? 8'hAA :
                  (bad_en && uo_out == bad_vec) ? bad_val : ref_alu(uo_out);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic [7:0] e_err, input logic [7:0] e_vec,
                        input logic [7:0] e_res, input logic [7:0] e_flg);
    ui_in[1:0] = 2'b00; #1; chk({tag, "/err_cnt"}, uo_out, e_err);
    ui_in[1:0] = 2'b01; #1; chk({tag, "/ff_vec"},  uo_out, e_vec);
    ui_in[1:0] = 2'b10; #1; chk({tag, "/ff_res"},  uo_out, e_res);
    ui_in[1:0] = 2'b11; #1; chk({tag, "/flags"},   uo_out, e_flg);
  endtask

  // last_idx is the final vector sampled before DONE.
  task automatic sweep(input string tag, input int last_idx);
    int n;
    n = (last_idx + 1) * (S + 1) + 3;
    @(negedge clk);
    ui_in[7] = 1'b1;
    ui_in[1:0] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "/first_vec"}, uo_out, 8'h00);
    ui_in[7] = 1'b0;
    repeat (n - 4) @(posedge clk);
    @(negedge clk);
    chk({tag, "/last_vec"}, uo_out, last_idx[7:0]);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] spot_idx [3];
    logic [7:0] spot_val [3];
    logic [7:0] ridx, rval;
    int last;
    spot_idx[0] = 8'hC5; spot_val[0] = 8'hFF;
    spot_idx[1] = 8'h48; spot_val[1] = 8'hFF;
    spot_idx[2] = 8'hBF; spot_val[2] = 8'h31;

    #3;
    chk("reset/uo_out", uo_out, 8'h00);
    status("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    sweep("clean", 255);
    status("clean", 8'h00, 8'h00, 8'h00, 8'hC0);

    bad_en = 1'b1; bad_vec = 8'h13; bad_val = 8'h04;
    sweep("bad13", STOP ? 8'h13 : 255);
    status("bad13", 8'h01, 8'h13, 8'h04, 8'hA0);

    for (int i = 0; i < 3; i++) begin
      bad_vec = spot_idx[i];
      bad_val = spot_val[i];
      sweep("spot_ok", 255);
      status("spot_ok", 8'h00, 8'h00, 8'h00, 8'hC0);
      bad_val = spot_val[i] ^ 8'h01;
      last = STOP ? int'(spot_idx[i]) : 255;
      sweep("spot_bad", last);
      status("spot_bad", 8'h01, spot_idx[i], bad_val, 8'hA0);
    end

    for (int i = 0; i < 2; i++) begin
      ridx = 8'($urandom_range(0, 255));
      rval = ref_alu(ridx) ^ 8'($urandom_range(1, 255));
      bad_vec = ridx;
      bad_val = rval;
      last = STOP ? int'(ridx) : 255;
      sweep("rand", last);
      status("rand", 8'h01, ridx, rval, 8'hA0);
    end

    bad_en = 1'b0;
    stuck = 1'b1;
    sweep("stuck", STOP ? 0 : 255);
    status("stuck", STOP ? 8'h01 : 8'hFF, 8'h00, 8'hAA, 8'hA0);
    stuck = 1'b0;

    // Mid-sweep abort at vector 0x40, with a start pulse during the run that must be ignored.
    bad_en = !STOP; bad_vec = 8'h13; bad_val = 8'h04;
    @(negedge clk);
    ui_in[7] = 1'b1;
    ui_in[1:0] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid/first_vec", uo_out, 8'h00);
    ui_in[7] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (295) @(posedge clk);
    @(negedge clk);
    chk("mid/vec40", uo_out, 8'h40);
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid/idle_flags", uo_out, STOP ? 8'h00 : 8'h20);
    status("mid", STOP ? 8'h00 : 8'h01, STOP ? 8'h00 : 8'h13,
           STOP ? 8'h00 : 8'h04, STOP ? 8'h00 : 8'h20);
    ena = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid/stays_idle", uo_out, STOP ? 8'h00 : 8'h20);

    rst_n = 1'b0;
    #1;
    chk("mid_rst/uo_out", uo_out, 8'h00);
    status("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bad_en = 1'b0;

    sweep("restart", 255);
    status("restart", 8'h00, 8'h00, 8'h00, 8'hC0);
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
